// File: rtl/ssd1331_pkg.sv
// rtl/ssd1331_pkg.sv - shared constants, init ROM and state encoding for the SSD1331 sequencer
//
// Purpose : init command list, display-on opcode, FSM state type and a
//           helper that turns a cycle count into the counter's terminal value.
// Ports   : none (package).
package ssd1331_pkg;

  localparam int CNT_W    = 24;
  localparam int IDX_W    = 6;
  localparam int INIT_LEN = 37;

  localparam logic [IDX_W-1:0] INIT_LAST      = IDX_W'(INIT_LEN - 1);
  localparam logic [7:0]       CMD_DISPLAY_ON = 8'hAF;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
    8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
    8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
    8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E
  };

  typedef enum logic [2:0] {
    S_PWR,
    S_RST_LOW,
    S_RST_WAIT,
    S_INIT_WAIT,
    S_VCC_WAIT,
    S_DISP_WAIT,
    S_USER_IDLE,
    S_USER_WAIT
  } state_t;

  // Counters run 0..N-1; a request for 0 cycles is treated as 1.
  function automatic logic [CNT_W-1:0] cnt_last(input int cycles);
    return (cycles <= 1) ? '0 : CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ssd1331_init_rom.sv
// rtl/ssd1331_init_rom.sv - combinational init command ROM, index to byte
//
// Purpose : look up one init command byte.
// Ports   : i_IDX  - ROM index (0..INIT_LEN-1, larger indices read 0)
//           o_BYTE - command byte, zero-extended to WIDTH
module ssd1331_init_rom
  import ssd1331_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [IDX_W-1:0] i_IDX,
  output logic [WIDTH-1:0] o_BYTE
);

  always_comb begin
    o_BYTE = '0;
    if (i_IDX <= INIT_LAST) begin
      o_BYTE = WIDTH'(INIT_ROM[i_IDX]);
    end
  end

endmodule

// File: rtl/ssd1331_cmd_sequencer.sv
// rtl/ssd1331_cmd_sequencer.sv - SSD1331 power-up/init sequencer feeding a MOSI serializer
//
// Purpose : runs PMODEN / RES# / VCCEN power-up, streams the init ROM and
//           display-on to the serializer, then forwards user bytes.
// Ports   : i_SCK, i_RST_N          - clock (rising edge), async active-low reset
//           i_TX_DONE               - serializer final-bit flag
//           i_REQ_VALID/DATA/DC     - user byte port, o_REQ_READY handshake
//           o_START, o_DATA, o_DC   - serializer start pulse, byte, D/C#
//           o_PMODEN/o_RES_N/o_VCCEN- panel power and reset pins
//           o_INIT_DONE             - high once display-on has gone out
module ssd1331_cmd_sequencer
  import ssd1331_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int RST_LOW_CYCLES  = 32,
  parameter int RST_WAIT_CYCLES = 32,
  parameter int VCC_WAIT_CYCLES = 625000
) (
  input  logic             i_SCK,
  input  logic             i_RST_N,
  input  logic             i_TX_DONE,
  input  logic             i_REQ_VALID,
  input  logic [WIDTH-1:0] i_REQ_DATA,
  input  logic             i_REQ_DC,
  output logic             o_REQ_READY,
  output logic             o_START,
  output logic [WIDTH-1:0] o_DATA,
  output logic             o_DC,
  output logic             o_PMODEN,
  output logic             o_RES_N,
  output logic             o_VCCEN,
  output logic             o_INIT_DONE
);

  localparam logic [CNT_W-1:0] RST_LOW_LAST  = cnt_last(RST_LOW_CYCLES);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = cnt_last(RST_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] VCC_WAIT_LAST = cnt_last(VCC_WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q, start_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              dc_q, dc_d;
  logic              pmoden_q, pmoden_d;
  logic              res_n_q, res_n_d;
  logic              vccen_q, vccen_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic [IDX_W-1:0]  rom_idx;
  logic [WIDTH-1:0]  rom_byte;
  logic              tx_done;

  // idx_q holds the byte in flight; the ROM is addressed one ahead so the
  // next byte is ready on the done edge. Outside init it addresses ROM[0].
  assign rom_idx = (state_q == S_INIT_WAIT) ? idx_q + IDX_W'(1) : '0;

  // A done flag on the cycle right after a start cannot belong to that
  // byte; ignoring it keeps o_START from firing on consecutive cycles.
  assign tx_done = i_TX_DONE && !start_q;

  ssd1331_init_rom #(.WIDTH(WIDTH)) u_rom (
    .i_IDX  (rom_idx),
    .o_BYTE (rom_byte)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    start_d  = 1'b0;
    data_d   = data_q;
    dc_d     = dc_q;
    pmoden_d = pmoden_q;
    res_n_d  = res_n_q;
    vccen_d  = vccen_q;
    done_d   = done_q;
    ready_d  = ready_q;

    unique case (state_q)
      S_PWR: begin
        pmoden_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_RST_LOW;
      end
      S_RST_LOW: begin
        if (cnt_q == RST_LOW_LAST) begin
          res_n_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == RST_WAIT_LAST) begin
          start_d = 1'b1;
          data_d  = rom_byte;
          dc_d    = 1'b0;
          idx_d   = '0;
          state_d = S_INIT_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INIT_WAIT: begin
        if (tx_done) begin
          if (idx_q < INIT_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            start_d = 1'b1;
            data_d  = rom_byte;
            dc_d    = 1'b0;
          end else begin
            vccen_d = 1'b1;
            cnt_d   = '0;
            state_d = S_VCC_WAIT;
          end
        end
      end
      S_VCC_WAIT: begin
        if (cnt_q == VCC_WAIT_LAST) begin
          start_d = 1'b1;
          data_d  = WIDTH'(CMD_DISPLAY_ON);
          dc_d    = 1'b0;
          state_d = S_DISP_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DISP_WAIT: begin
        if (tx_done) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_USER_IDLE;
        end
      end
      S_USER_IDLE: begin
        if (i_REQ_VALID) begin
          data_d  = i_REQ_DATA;
          dc_d    = i_REQ_DC;
          start_d = 1'b1;
          ready_d = 1'b0;
          state_d = S_USER_WAIT;
        end
      end
      S_USER_WAIT: begin
        if (tx_done) begin
          ready_d = 1'b1;
          state_d = S_USER_IDLE;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  always_ff @(posedge i_SCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= S_PWR;
      cnt_q    <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      dc_q     <= 1'b0;
      pmoden_q <= 1'b0;
      res_n_q  <= 1'b0;
      vccen_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      data_q   <= data_d;
      dc_q     <= dc_d;
      pmoden_q <= pmoden_d;
      res_n_q  <= res_n_d;
      vccen_q  <= vccen_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign o_START     = start_q;
  assign o_DATA      = data_q;
  assign o_DC        = dc_q;
  assign o_PMODEN    = pmoden_q;
  assign o_RES_N     = res_n_q;
  assign o_VCCEN     = vccen_q;
  assign o_INIT_DONE = done_q;
  assign o_REQ_READY = ready_q;

endmodule
